cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//   Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   Two-level lookahead: GROUP-bit carry groups, then a group-level lookahead across groups.
//   Successor to the fixed 32-bit combinational CLA. Serves as the integer add/sub datapath
//   in the arithmetic units. Adds operand width, pipelining, backpressure, sub mode and flags.
// PARAMETERS
//   WIDTH   32  operand/result width; must be a multiple of GROUP (elaboration $error otherwise)
//   GROUP   4   bits per first-level carry group (2..8)
//   STAGES  2   pipeline register stages, 1 or 2 (any other value: elaboration $error)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block accepts a beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add); borrow-in (sub)
//   sub        in   1      0: a+b+cin; 1: a-b-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   cout       out  1      raw carry-out of the MSB (sub: 1 = no borrow)
//   overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): all stage valids=0; out_valid=0, sum=0, cout=0,
//     overflow=0; in_ready=1 on the first clock after reset deasserts.
//   - Operand prep: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. g=a&b_eff, p=a^b_eff.
//   - Group lookahead: per group P=&p, G by standard recurrence; inter-group carries
//     c[k*GROUP] = G[k-1] | P[k-1]&c[(k-1)*GROUP]; sum[i] = p[i]^c[i].
//   - overflow = (a[MSB]==b_eff[MSB]) & (sum[MSB]!=a[MSB]); cout = carry out of bit WIDTH-1.
//   - STAGES=1: full CLA combinational, one output register; latency 1 cycle.
//   - STAGES=2: stage1 registers p, g, c0, a[MSB], b_eff[MSB], group P/G; stage2 does the
//     inter-group lookahead, sum and flags into the output register. Latency 2 cycles.
//   - Handshake: beat accepted when in_valid & in_ready. Stage n loads when its successor is
//     empty or advancing; in_ready = ~v[0] | adv[0]. Full throughput (1 beat/cycle) while
//     out_ready=1; no bubbles inserted, no beats dropped or duplicated.
//   - out_valid & ~out_ready: sum/cout/overflow held stable; pipeline stalls; in_ready falls
//     once every stage holds a beat.
//   - Simultaneous out-transfer and in-accept on a full pipe: both occur, occupancy unchanged.
//   - Operand inputs are don't-care while in_valid=0; no registers update on un-accepted beats.
//   - rst mid-operation: in-flight beats discarded, outputs return to reset values at once.
// CONFIGURATION
//   CLA_ADDER_SAT_EN defined: extra input sat (1 bit, after sub); when sat=1 and overflow=1,
//     sum clamps to signed max (0x7FF..F) if a[MSB]=0, signed min (0x800..0) if a[MSB]=1;
//     overflow still reports 1; cout unchanged. Clamp is in the final stage, latency unchanged.
//   Not defined: no sat port; sum is always the wrapped result.
// STRUCTURE
//   Package cla_pkg: localparams for max GROUP, STAGES limits; typedef of the per-stage payload
//     struct (p, g, c0, msb bits, group P/G); function clog2 for group count.
//   Sub-module cla_group: GROUP-bit lookahead group, in p/g/cin -> internal carries, group P/G.
//   Instantiated WIDTH/GROUP times for level 1 and once (width WIDTH/GROUP) for level 2.
// TESTING
//   1 Reset: assert rst mid-stream with 2 beats in flight -> out_valid=0, sum=0 same cycle;
//     after release, next beat a=1,b=1 emerges after STAGES cycles with sum=2.
//   2 Carry ripple, WIDTH=32: a=0xFFFF_FFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, overflow=0.
//   3 Subtract: a=5, b=7, cin=0, sub=1 -> sum=0xFFFF_FFFE, cout=0, overflow=0; a=0x8000_0000,
//     b=1, sub=1 -> sum=0x7FFF_FFFF, overflow=1.
//   4 Backpressure: 8 back-to-back beats, out_ready low for cycles 3-6 -> all 8 results
//     in order, held stable while stalled, in_ready low only when pipe full.
//   5 Saturation (CLA_ADDER_SAT_EN, sat=1): a=0x7FFF_FFFF, b=1 -> sum=0x7FFF_FFFF, overflow=1;
//     sat=0 -> sum=0x8000_0000.
//   6 Random: 10k beats, random valid/ready, WIDTH in {16,32,64}, GROUP in {4,8},
//     STAGES in {1,2} -> every result matches a behavioural {cout,sum} reference model.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared limits, per-stage metadata type and helpers for the pipelined CLA adder.
// The CLA_ADDER_SAT_EN macro adds the saturation flag to the carried metadata.
package cla_pkg;
  localparam int GROUP_MIN  = 2;
  localparam int GROUP_MAX  = 8;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 2;

  // Scalar part of the stage-1 payload; the width-dependent p/g/group P/G vectors sit beside it.
  typedef struct packed {
    logic c0;
    logic a_msb;
    logic b_msb;
`ifdef CLA_ADDER_SAT_EN
    logic sat;
`endif
  } cla_meta_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cla_group.sv
// N-bit lookahead group: per-bit carries from p/g/cin plus group propagate/generate.
module cla_group #(
  parameter int N = 4
) (
  input  logic [N-1:0] p_i,
  input  logic [N-1:0] g_i,
  input  logic         cin_i,
  output logic [N-1:0] c_o,
  output logic         gp_o,
  output logic         gg_o
);
  always_comb begin
    logic cc;
    logic gacc;
    cc   = cin_i;
    gacc = 1'b0;
    c_o  = '0;
    for (int i = 0; i < N; i++) begin
      c_o[i] = cc;
      cc     = g_i[i] | (p_i[i] & cc);
      gacc   = g_i[i] | (p_i[i] & gacc);
    end
    gp_o = &p_i;
    gg_o = gacc;
  end
endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_ADDER_SAT_EN to add the sat input (signed saturation on overflow).
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  if ((WIDTH % GROUP) != 0 || GROUP < GROUP_MIN || GROUP > GROUP_MAX) begin : g_bad_group
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP, GROUP in 2..8");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("cla_adder_pipe: STAGES must be 1 or 2");
  end

  // Operand prep and first-level group P/G.
  logic [WIDTH-1:0] b_eff, p_e, g_e, unused_c_e;
  logic [NG-1:0]    gp_e, gg_e;
  cla_meta_t        meta_e;

  assign b_eff        = sub ? ~b : b;
  assign p_e          = a ^ b_eff;
  assign g_e          = a & b_eff;
  assign meta_e.c0    = sub ? ~cin : cin;
  assign meta_e.a_msb = a[MSB];
  assign meta_e.b_msb = b_eff[MSB];
`ifdef CLA_ADDER_SAT_EN
  assign meta_e.sat   = sat;
`endif

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp_early
    cla_group #(.N(GROUP)) u_grp (
      .p_i  (p_e[gi*GROUP +: GROUP]),
      .g_i  (g_e[gi*GROUP +: GROUP]),
      .cin_i(1'b0),
      .c_o  (unused_c_e[gi*GROUP +: GROUP]),
      .gp_o (gp_e[gi]),
      .gg_o (gg_e[gi])
    );
  end

  // Valid chain: a stage loads when it is empty or its successor takes its beat.
  logic [STAGES-1:0] v_q, v_d, v_in, load;
  logic [STAGES:0]   rdy;

  assign rdy[STAGES] = out_ready;
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_vld
    assign rdy[gi] = ~v_q[gi] | rdy[gi+1];
    if (gi == 0) begin : g_first
      assign v_in[gi] = in_valid;
    end else begin : g_next
      assign v_in[gi] = v_q[gi-1];
    end
    assign load[gi] = rdy[gi] & v_in[gi];
    assign v_d[gi]  = rdy[gi] ? v_in[gi] : v_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];

  // Operands seen by the final stage: registered when split in two, else straight through.
  logic [WIDTH-1:0] p_l, g_l;
  logic [NG-1:0]    gp_l, gg_l;
  cla_meta_t        meta_l;

  if (STAGES == 2) begin : g_s1
    logic [WIDTH-1:0] p_q, g_q;
    logic [NG-1:0]    gp_q, gg_q;
    cla_meta_t        meta_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_q    <= '0;
        g_q    <= '0;
        gp_q   <= '0;
        gg_q   <= '0;
        meta_q <= '0;
      end else if (load[0]) begin
        p_q    <= p_e;
        g_q    <= g_e;
        gp_q   <= gp_e;
        gg_q   <= gg_e;
        meta_q <= meta_e;
      end
    end
    assign p_l    = p_q;
    assign g_l    = g_q;
    assign gp_l   = gp_q;
    assign gg_l   = gg_q;
    assign meta_l = meta_q;
  end else begin : g_s0
    assign p_l    = p_e;
    assign g_l    = g_e;
    assign gp_l   = gp_e;
    assign gg_l   = gg_e;
    assign meta_l = meta_e;
  end

  // Group-level lookahead supplies each group's carry-in, then bit carries within groups.
  logic [NG-1:0]    gc, unused_gp_l, unused_gg_l;
  logic             gp2, gg2;
  logic [WIDTH-1:0] c_l, sum_raw, sum_fin;
  logic             cout_l, ovf_l;

  cla_group #(.N(NG)) u_lvl2 (
    .p_i  (gp_l),
    .g_i  (gg_l),
    .cin_i(meta_l.c0),
    .c_o  (gc),
    .gp_o (gp2),
    .gg_o (gg2)
  );

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp_late
    cla_group #(.N(GROUP)) u_grp (
      .p_i  (p_l[gi*GROUP +: GROUP]),
      .g_i  (g_l[gi*GROUP +: GROUP]),
      .cin_i(gc[gi]),
      .c_o  (c_l[gi*GROUP +: GROUP]),
      .gp_o (unused_gp_l[gi]),
      .gg_o (unused_gg_l[gi])
    );
  end

  assign sum_raw = p_l ^ c_l;
  assign cout_l  = gg2 | (gp2 & meta_l.c0);
  assign ovf_l   = (meta_l.a_msb == meta_l.b_msb) & (sum_raw[MSB] != meta_l.a_msb);

`ifdef CLA_ADDER_SAT_EN
  // Clamp toward the sign of a: positive overflow -> 0x7F..F, negative -> 0x80..0.
  assign sum_fin = (meta_l.sat & ovf_l) ? {meta_l.a_msb, {MSB{~meta_l.a_msb}}} : sum_raw;
`else
  assign sum_fin = sum_raw;
`endif

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load[STAGES-1]) begin
      sum_q  <= sum_fin;
      cout_q <= cout_l;
      ovf_q  <= ovf_l;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed self-checking bench for cla_adder_pipe (WIDTH=32, GROUP=4, STAGES=2).
module tb_cla_adder_pipe;
  localparam int WIDTH  = 32;
  localparam int GROUP  = 4;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
`ifdef CLA_ADDER_SAT_EN
  logic             sat = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
`ifdef CLA_ADDER_SAT_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One beat through an idle pipe with out_ready high; checks latency and all result fields.
  task automatic run_beat(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vcin, input logic vsub, input logic [31:0] esum,
                          input logic ecout, input logic eovf);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    $display("beat %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, va, vb, vcin, vsub, sum, cout, overflow, lat);
    check({tag, "_lat"}, 64'(lat), 64'(STAGES));
    check({tag, "_sum"}, 64'(sum), 64'(esum));
    check({tag, "_cout"}, 64'(cout), 64'(ecout));
    check({tag, "_ovf"}, 64'(overflow), 64'(eovf));
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] held_sum;
    logic        held_v;
    logic        exp_rdy;
    int          sent, rcv, occ;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed arithmetic
    run_beat("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_beat("sub5m7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_beat("subminm1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_beat("addposov", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_beat("addplain", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    run_beat("subbrw",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);
    run_beat("subzero",  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_beat("addneg",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_beat("addnegov", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 3..6
    sent = 0; rcv = 0; occ = 0; held_v = 1'b0; held_sum = '0;
    cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 8) begin
        a = 32'(sent) * 32'h2468_ACE1;
        b = 32'hFFFF_FFFF - 32'(sent) * 32'd7;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = (occ < STAGES) || out_ready;
      $display("bp cyc=%0d in_valid=%0d in_ready=%0d out_valid=%0d out_ready=%0d sum=%h",
               cyc, in_valid, in_ready, out_valid, out_ready, sum);
      check("bp_in_ready", 64'(in_ready), 64'(exp_rdy));
      if (held_v) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_sum", 64'(sum), 64'(held_sum));
      end
      held_v = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check("bp_sum", 64'(sum), 64'(exp_q.pop_front()));
          rcv++;
        end else begin
          held_v   = 1'b1;
          held_sum = sum;
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(a + b);
        sent++;
        occ++;
      end
      if (out_valid && out_ready) occ--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 64'(rcv), 64'd8);

    // Reset mid-stream with two beats in flight
    @(negedge clk);
    a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'd10; b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    check("mid_pre_sum", 64'(sum), 64'd7);
    #1 rst = 1'b1;
    #1;
    $display("mid reset: out_valid=%0d sum=%h cout=%0d", out_valid, sum, cout);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_valid", 64'(out_valid), 64'd0);
    check("mid_post_in_ready", 64'(in_ready), 64'd1);
    run_beat("after_rst", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);

`ifdef CLA_ADDER_SAT_EN
    sat = 1'b1;
    run_beat("sat_on",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_beat("sat_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
    sat = 1'b0;
    run_beat("sat_off", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
